// File: rtl/fsm_test_pkg.sv
// Shared types and default constants for the fsm test-support blocks
// (response compactor and its MISR core).
package fsm_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam logic [15:0] DEF_POLY  = 16'h1021;
  localparam logic [15:0] DEF_SEED  = 16'h0000;
  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: seed load, one compaction step per
// enabled clock (s_in at bit0, so_in at bit1), and a serial shift path.
module misr_core
  import fsm_test_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             shift,
  input  logic             s_in,
  input  logic             so_in,
  input  logic             si,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] fb_term;
  logic [WIDTH-1:0] inj_term;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    fb_term  = sig[WIDTH-1] ? POLY : '0;
    inj_term = {{(WIDTH-2){1'b0}}, so_in, s_in};
    step_val = (sig << 1) ^ fb_term ^ inj_term;
  end

  // load outranks step, which outranks the serial shift
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (step) begin
      sig <= step_val;
    end else if (shift) begin
      sig <= {sig[WIDTH-2:0], si};
    end
  end

endmodule

// File: rtl/fsm_resp_misr.sv
// Response compactor for the scan-inserted fsm block: folds s and scan-out
// into a MISR over n_cycles, then compares against exp_sig.
// Optional signature unload over scan pins: define RESP_MISR_SCAN_EN.
module fsm_resp_misr
  import fsm_test_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int unsigned      CNT_W = DEF_CNT_W
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic             s_in,
  input  logic             so_in,
  input  logic [WIDTH-1:0] exp_sig,
`ifdef RESP_MISR_SCAN_EN
  input  logic             se,
  input  logic             si,
  output logic             so,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             shift;
  logic             scan_in;

  always_comb begin
    load = (state == IDLE) && start;
    step = (state == RUN);
  end

`ifdef RESP_MISR_SCAN_EN
  always_comb begin
    shift   = (state == IDLE) && !start && se;
    scan_in = si;
    so      = sig[WIDTH-1];
  end
`else
  always_comb begin
    shift   = 1'b0;
    scan_in = 1'b0;
  end
`endif

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .ck    (ck),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .shift (shift),
    .s_in  (s_in),
    .so_in (so_in),
    .si    (scan_in),
    .sig   (sig)
  );

  // busy/done are registered alongside the state so they track it exactly
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pass <= 1'b0;
            if (n_cycles != '0) begin
              state <= RUN;
              cnt   <= n_cycles;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          pass  <= (sig == exp_sig);
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_resp_misr.sv
// Directed bench for fsm_resp_misr with hand-computed signatures.
// Scan unload section is built when RESP_MISR_SCAN_EN is defined.
module tb_fsm_resp_misr;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n_cycles;
  logic        s_in;
  logic        so_in;
  logic [15:0] exp_sig;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] sig;
`ifdef RESP_MISR_SCAN_EN
  logic        se;
  logic        si;
  logic        so;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  fsm_resp_misr dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .start    (start),
    .n_cycles (n_cycles),
    .s_in     (s_in),
    .so_in    (so_in),
    .exp_sig  (exp_sig),
`ifdef RESP_MISR_SCAN_EN
    .se       (se),
    .si       (si),
    .so       (so),
`endif
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .sig      (sig)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // one full clock; always lands on a falling edge
  task automatic cyc();
    @(negedge ck);
  endtask

  task automatic begin_run(input logic [15:0] n);
    start    = 1'b1;
    n_cycles = n;
    cyc();
    start    = 1'b0;
  endtask

`ifdef RESP_MISR_SCAN_EN
  logic [15:0] load_bits;
  logic [15:0] so_pat;
`endif

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    n_cycles = '0;
    s_in     = 1'b0;
    so_in    = 1'b0;
    exp_sig  = '0;
`ifdef RESP_MISR_SCAN_EN
    se = 1'b0;
    si = 1'b0;
`endif
    repeat (2) cyc();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_sig", sig, 16'h0000);
    rst_n = 1'b1;
    cyc();

    // single-bit inject, N=2
    exp_sig = 16'h0002;
    begin_run(16'd2);
    check_eq("t1_busy", busy, 1);
    s_in = 1'b1; so_in = 1'b0;
    cyc();
    check_eq("t1_sig1", sig, 16'h0001);
    check_eq("t1_done_early", done, 0);
    s_in = 1'b0;
    cyc();
    check_eq("t1_sig2", sig, 16'h0002);
    check_eq("t1_done", done, 1);
    check_eq("t1_busy_off", busy, 0);
    check_eq("t1_pass_not_yet", pass, 0);
    cyc();
    check_eq("t1_done_off", done, 0);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_sig_frozen", sig, 16'h0002);

    // feedback: N=16 with one leading 1 lands on the MSB
    exp_sig = 16'h8000;
    begin_run(16'd16);
    check_eq("t2_pass_cleared", pass, 0);
    s_in = 1'b1;
    cyc();
    s_in = 1'b0;
    repeat (15) cyc();
    check_eq("t2_sig", sig, 16'h8000);
    check_eq("t2_done", done, 1);
    cyc();
    check_eq("t2_pass", pass, 1);

    // N=17: one more step pushes the MSB through the polynomial
    exp_sig = 16'h1021;
    begin_run(16'd17);
    s_in = 1'b1;
    cyc();
    s_in = 1'b0;
    repeat (15) cyc();
    check_eq("t3_sig16", sig, 16'h8000);
    check_eq("t3_busy", busy, 1);
    cyc();
    check_eq("t3_sig", sig, 16'h1021);
    check_eq("t3_done", done, 1);
    cyc();
    check_eq("t3_pass", pass, 1);

    // both inputs, matching then mismatching expected value
    exp_sig = 16'h0003;
    begin_run(16'd1);
    s_in = 1'b1; so_in = 1'b1;
    cyc();
    s_in = 1'b0; so_in = 1'b0;
    check_eq("t4_sig", sig, 16'h0003);
    check_eq("t4_done", done, 1);
    cyc();
    check_eq("t4_pass", pass, 1);
    exp_sig = 16'h0002;
    begin_run(16'd1);
    s_in = 1'b1; so_in = 1'b1;
    cyc();
    s_in = 1'b0; so_in = 1'b0;
    check_eq("t5_sig", sig, 16'h0003);
    cyc();
    check_eq("t5_pass", pass, 0);

    // zero count goes straight to DONE and reseeds
    exp_sig = 16'h0000;
    begin_run(16'd0);
    check_eq("t6_done", done, 1);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_sig", sig, 16'h0000);
    cyc();
    check_eq("t6_pass", pass, 1);
    check_eq("t6_done_off", done, 0);
    exp_sig = 16'h0005;
    begin_run(16'd0);
    check_eq("t7_done", done, 1);
    cyc();
    check_eq("t7_pass", pass, 0);

    // start during RUN and during the DONE exit cycle is ignored
    exp_sig = 16'h0000;
    begin_run(16'd4);
    cyc();
    start = 1'b1; n_cycles = 16'd9;
    cyc();
    start = 1'b0;
    check_eq("t8_busy_mid", busy, 1);
    check_eq("t8_done_mid", done, 0);
    cyc();
    check_eq("t8_done_k3", done, 0);
    cyc();
    check_eq("t8_done_k4", done, 1);
    check_eq("t8_busy_k4", busy, 0);
    start = 1'b1; n_cycles = 16'd3;
    cyc();
    start = 1'b0;
    check_eq("t8_busy_exit", busy, 0);
    check_eq("t8_done_exit", done, 0);
    check_eq("t8_pass", pass, 1);
    cyc();
    check_eq("t8_busy_after", busy, 0);

    // sig frozen in IDLE regardless of responses
    s_in = 1'b1; so_in = 1'b1;
    cyc();
    check_eq("t9_idle_frozen", sig, 16'h0000);
    s_in = 1'b0; so_in = 1'b0;

    // max count is accepted; asynchronous reset aborts mid-run
    begin_run(16'hFFFF);
    check_eq("t10_busy", busy, 1);
    s_in = 1'b1;
    cyc();
    s_in = 1'b0;
    repeat (2) cyc();
    check_eq("t10_sig", sig, 16'h0004);
    check_eq("t10_busy_run", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t10_rst_busy", busy, 0);
    check_eq("t10_rst_done", done, 0);
    check_eq("t10_rst_pass", pass, 0);
    check_eq("t10_rst_sig", sig, 16'h0000);
    cyc();
    rst_n = 1'b1;
    cyc();
    check_eq("t10_no_done", done, 0);
    check_eq("t10_idle", busy, 0);

`ifdef RESP_MISR_SCAN_EN
    // build 0xA5C3 serially on s_in, then unload over the scan pins
    load_bits = 16'hA5C3;
    so_pat    = 16'b1010_0101_1100_0011;
    exp_sig   = 16'hA5C3;
    begin_run(16'd16);
    for (int i = 15; i >= 0; i--) begin
      s_in = load_bits[i];
      cyc();
    end
    s_in = 1'b0;
    check_eq("sc_sig", sig, 16'hA5C3);
    check_eq("sc_done", done, 1);
    se = 1'b1; si = 1'b0;
    cyc();
    check_eq("sc_pass", pass, 1);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("sc_so%0d", i), so, so_pat[15-i]);
      cyc();
    end
    se = 1'b0;
    check_eq("sc_sig_end", sig, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
